// File: rtl/clock_set_ctrl_if.sv
// Front-panel bus between the button pins / prescaler and the set-mode controller.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       run_en;
  logic [5:0] field_sel;
  logic [5:0] incr;
  logic [5:0] dcr;
  logic       blink;

  // Stimulus side: drives ticks and raw buttons, observes controller outputs.
  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    input  run_en, field_sel, incr, dcr, blink
  );

  // Controller side.
  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    output run_en, field_sel, incr, dcr, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for the century clock: button sync/debounce, RUN/SET field
// FSM, per-field incr/dcr pulses with auto-repeat, idle timeout and blink control.
module clock_set_ctrl #(
  parameter int DEB_CYCLES = 250000,
  parameter int REP_DLY    = 25000000,
  parameter int REP_PER    = 5000000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REP_DLY + REP_PER + 1);
  localparam int TW = $clog2(TIMEOUT_S + 2);

  typedef enum logic [2:0] {
    RUN = 3'd0, S_SEC = 3'd1, S_MIN = 3'd2, S_HOUR = 3'd3,
    S_DAY = 3'd4, S_MONTH = 3'd5, S_YEAR = 3'd6
  } state_e;

  // Button index: 0 = mode, 1 = up, 2 = down.
  logic [2:0]    raw, sync1_q, sync2_q, deb_q, deb_prev_q, ev;
  logic [DW-1:0] deb_cnt_q [3];

  state_e        state_q, state_d;
  logic [RW-1:0] rep_cnt_q;
  logic          rep_act_q, rep_dn_q, rep_first_q;
  logic [TW-1:0] idle_q;
  logic          run_en_q, blink_q;
  logic [5:0]    field_sel_q, incr_q, dcr_q;

  logic mode_ev, up_ev, dn_ev, timeout, hold;
  logic sel_hi, oth_hi, held_ok, rep_due, rep_fire, new_up, new_dn, fire_up, fire_dn;

  function automatic logic [5:0] fsel(input state_e s);
    case (s)
      S_SEC:   fsel = 6'b000001;
      S_MIN:   fsel = 6'b000010;
      S_HOUR:  fsel = 6'b000100;
      S_DAY:   fsel = 6'b001000;
      S_MONTH: fsel = 6'b010000;
      S_YEAR:  fsel = 6'b100000;
      default: fsel = 6'b000000;
    endcase
  endfunction

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  // Two-flop synchronisers, then a debounce counter per button; the counter only
  // runs while the synced sample disagrees with the current debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int b = 0; b < 3; b++) deb_cnt_q[b] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == deb_q[b]) begin
          deb_cnt_q[b] <= '0;
        end else if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
          deb_q[b]     <= sync2_q[b];
          deb_cnt_q[b] <= '0;
        end else begin
          deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Press events, next state and pulse decisions.
  always_comb begin
    ev      = deb_q & ~deb_prev_q;
    mode_ev = ev[0];
    // A press with the opposite button already down counts as "both held": ignored.
    up_ev   = ev[1] & ~deb_q[2];
    dn_ev   = ev[2] & ~deb_q[1];
    timeout = (TIMEOUT_S != 0) && (idle_q == TW'(TIMEOUT_S));

    state_d = state_q;
    case (state_q)
      RUN:                                   state_d = mode_ev ? S_SEC : RUN;
      S_SEC, S_MIN, S_HOUR, S_DAY, S_MONTH:  state_d = mode_ev ? state_e'(state_q + 3'd1)
                                                     : (timeout ? RUN : state_q);
      S_YEAR:                                state_d = (mode_ev || timeout) ? RUN : S_YEAR;
      default:                               state_d = RUN;
    endcase

    // Pulses only while sitting in a set state that is not about to change.
    hold     = (state_q != RUN) && (state_d == state_q);
    sel_hi   = rep_dn_q ? deb_q[2] : deb_q[1];
    oth_hi   = rep_dn_q ? deb_q[1] : deb_q[2];
    held_ok  = sel_hi & ~oth_hi;
    rep_due  = rep_first_q ? (rep_cnt_q == RW'(REP_DLY - 1)) : (rep_cnt_q == RW'(REP_PER - 1));
    rep_fire = hold & rep_act_q & held_ok & rep_due;
    new_up   = hold & up_ev;
    new_dn   = hold & dn_ev;
    fire_up  = new_up | (rep_fire & ~rep_dn_q);
    fire_dn  = new_dn | (rep_fire & rep_dn_q);
  end

  // FSM state, auto-repeat tracker, idle timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_dn_q    <= 1'b0;
      rep_first_q <= 1'b0;
      idle_q      <= '0;
      run_en_q    <= 1'b1;
      field_sel_q <= '0;
      incr_q      <= '0;
      dcr_q       <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= (state_d == RUN);
      field_sel_q <= fsel(state_d);
      incr_q      <= fire_up ? fsel(state_q) : 6'b0;
      dcr_q       <= fire_dn ? fsel(state_q) : 6'b0;

      // Repeat only continues from a fresh press; field change or both-held kills it.
      if (!hold) begin
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
      end else if (new_up || new_dn) begin
        rep_act_q   <= 1'b1;
        rep_dn_q    <= new_dn;
        rep_first_q <= 1'b1;
        rep_cnt_q   <= '0;
      end else if (rep_act_q && held_ok) begin
        if (rep_fire) begin
          rep_first_q <= 1'b0;
          rep_cnt_q   <= '0;
        end else begin
          rep_cnt_q <= rep_cnt_q + 1'b1;
        end
      end else begin
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
      end

      // Any press clears the idle timer ahead of a coincident tick.
      if (state_d == RUN || (|ev))  idle_q <= '0;
      else if (bus.tick_1hz)        idle_q <= idle_q + 1'b1;

      if (state_d == RUN)                 blink_q <= 1'b0;
      else if (state_d != state_q)        blink_q <= 1'b1;
      else if ((|incr_q) || (|dcr_q))     blink_q <= 1'b1;
      else if (bus.tick_1hz)              blink_q <= ~blink_q;
    end
  end

  assign bus.run_en    = run_en_q;
  assign bus.field_sel = field_sel_q;
  assign bus.incr      = incr_q;
  assign bus.dcr       = dcr_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/repeat/timeout parameters.
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   inc_cyc[$];
  logic [5:0] inc_val[$];
  int   dcr_n = 0;
  int   inv_bad = 0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.DEB_CYCLES(4), .REP_DLY(20), .REP_PER(5), .TIMEOUT_S(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|bus.incr) begin
        inc_cyc.push_back(cyc);
        inc_val.push_back(bus.incr);
      end
      if (|bus.dcr) dcr_n <= dcr_n + 1;
      if ($countones({bus.incr, bus.dcr}) > 1) inv_bad <= inv_bad + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mode_press();
    bus.btn_mode = 1'b1; step(10);
    bus.btn_mode = 1'b0; step(10);
  endtask

  task automatic up_press(input int hold);
    bus.btn_up = 1'b1; step(hold);
    bus.btn_up = 1'b0; step(10);
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1; step(1);
    bus.tick_1hz = 1'b0;
  endtask

  logic [5:0] exp_fs [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                             6'b010000, 6'b100000, 6'b000000};
  int exp_off [7] = '{0, 20, 25, 30, 35, 40, 45};
  int mark, dmark;

  initial begin
    rst_n = 1'b0;
    bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    step(3);
    chk("rst_run_en", 32'(bus.run_en), 32'd1);
    chk("rst_field_sel", 32'(bus.field_sel), 32'd0);
    chk("rst_incr_dcr", 32'({bus.incr, bus.dcr}), 32'd0);
    chk("rst_blink", 32'(bus.blink), 32'd0);
    rst_n = 1'b1;
    step(3);

    // 1: mode walk through all fields and back to RUN
    mark = inc_cyc.size(); dmark = dcr_n;
    for (int i = 0; i < 7; i++) begin
      mode_press();
      chk($sformatf("walk_fs%0d", i), 32'(bus.field_sel), 32'(exp_fs[i]));
      chk($sformatf("walk_run%0d", i), 32'(bus.run_en), (i == 6) ? 32'd1 : 32'd0);
    end
    chk("walk_no_pulse", 32'(inc_cyc.size() - mark + dcr_n - dmark), 32'd0);

    // 2: glitches filtered, clean press gives one incr in S_SEC
    mode_press();
    chk("sec_blink_entry", 32'(bus.blink), 32'd1);
    mark = inc_cyc.size();
    for (int i = 0; i < 5; i++) begin
      bus.btn_up = 1'b1; step(3);
      bus.btn_up = 1'b0; step(3);
    end
    step(10);
    chk("glitch_no_incr", 32'(inc_cyc.size() - mark), 32'd0);
    up_press(8);
    chk("sec_one_incr", 32'(inc_cyc.size() - mark), 32'd1);
    chk("sec_incr_val", 32'(inc_val[inc_cyc.size() - 1]), 32'h01);

    // 3: auto-repeat in S_YEAR
    for (int i = 0; i < 5; i++) mode_press();
    chk("year_fs", 32'(bus.field_sel), 32'h20);
    mark = inc_cyc.size(); dmark = dcr_n;
    bus.btn_up = 1'b1; step(48);
    bus.btn_up = 1'b0; step(15);
    chk("rep_count", 32'(inc_cyc.size() - mark), 32'd7);
    if (inc_cyc.size() - mark == 7)
      for (int i = 0; i < 7; i++) begin
        chk($sformatf("rep_off%0d", i), 32'(inc_cyc[mark + i] - inc_cyc[mark]), 32'(exp_off[i]));
        chk($sformatf("rep_val%0d", i), 32'(inc_val[mark + i]), 32'h20);
      end
    chk("rep_no_dcr", 32'(dcr_n - dmark), 32'd0);

    // 4: up+down together in S_HOUR
    mode_press();
    chk("year_to_run", 32'(bus.run_en), 32'd1);
    for (int i = 0; i < 3; i++) mode_press();
    chk("hour_fs", 32'(bus.field_sel), 32'h04);
    mark = inc_cyc.size(); dmark = dcr_n;
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; step(40);
    chk("both_no_pulse", 32'(inc_cyc.size() - mark + dcr_n - dmark), 32'd0);
    bus.btn_down = 1'b0; step(15);
    chk("down_rel_no_pulse", 32'(inc_cyc.size() - mark + dcr_n - dmark), 32'd0);
    bus.btn_up = 1'b0; step(10);
    up_press(8);
    chk("hour_one_incr", 32'(inc_cyc.size() - mark), 32'd1);
    chk("hour_incr_val", 32'(inc_val[inc_cyc.size() - 1]), 32'h04);

    // 5: idle timeout in S_MIN, then restart of the timer by a press
    for (int i = 0; i < 6; i++) mode_press();
    chk("min_fs", 32'(bus.field_sel), 32'h02);
    chk("min_blink_entry", 32'(bus.blink), 32'd1);
    tick(); chk("blink_tog1", 32'(bus.blink), 32'd0); step(3);
    tick(); chk("blink_tog2", 32'(bus.blink), 32'd1); step(3);
    chk("to_run_before", 32'(bus.run_en), 32'd0);
    tick(); chk("to_run_tickcyc", 32'(bus.run_en), 32'd0);
    step(1); chk("to_run_after", 32'(bus.run_en), 32'd1);
    chk("to_fs_after", 32'(bus.field_sel), 32'd0);
    step(3);
    mode_press(); mode_press();
    tick(); step(3);
    tick(); step(3);
    up_press(8);
    tick(); step(1); chk("press_reset_t1", 32'(bus.run_en), 32'd0); step(2);
    tick(); step(3);
    tick(); chk("press_reset_tickcyc", 32'(bus.field_sel), 32'h02);
    step(1); chk("press_reset_to", 32'(bus.run_en), 32'd1);
    step(3);

    // 6: async reset mid-repeat in S_DAY
    for (int i = 0; i < 4; i++) mode_press();
    chk("day_fs", 32'(bus.field_sel), 32'h08);
    mark = inc_cyc.size();
    bus.btn_up = 1'b1; step(32);
    chk("day_two_pulses", 32'(inc_cyc.size() - mark), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_run_en", 32'(bus.run_en), 32'd1);
    chk("arst_field_sel", 32'(bus.field_sel), 32'd0);
    chk("arst_incr_dcr", 32'({bus.incr, bus.dcr}), 32'd0);
    chk("arst_blink", 32'(bus.blink), 32'd0);
    bus.btn_up = 1'b0;
    step(2);
    rst_n = 1'b1;
    mark = inc_cyc.size();
    step(40);
    chk("post_rst_no_pulse", 32'(inc_cyc.size() - mark), 32'd0);
    chk("post_rst_run_en", 32'(bus.run_en), 32'd1);
    chk("post_rst_fs", 32'(bus.field_sel), 32'd0);
    chk("onehot_invariant", 32'(inv_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
